sync_event_arbiter: RTL and testbench
=====================================

// Module: sync_event_arbiter
//
// PURPOSE
//   Conditions N_CH asynchronous input lines and merges them into one event stream.
//   Each channel has its own 2-flip-flop synchronizer stage (s2ff), then a debouncer,
//   then a rising-edge detector that sets a per-channel pending bit.
//   A round-robin scheduler passes pending events, one at a time, to a single
//   valid/ready event port. The block sits between board inputs (buttons, strobes)
//   and the consumer logic.
//
// PARAMETERS
//   N_CH        4                 number of input channels, >=2 (power of 2 not required)
//   ID_W        $clog2(N_CH)      width of evt_id
//   DEB_CYCLES  16                cycles a new synchronized level must hold before it is accepted, >=1
//   CNT_W       $clog2(DEB_CYCLES)+1   width of each debounce counter
//
// PORTS
//   clk        in   1      clock; all logic on posedge
//   rst_n      in   1      synchronous, active-low reset
//   async_in   in   N_CH   raw asynchronous inputs, one per channel
//   evt_ready  in   1      consumer accepts the event presented this cycle
//   ovf_clr    in   N_CH   per-channel clear of the ovf flag
//   evt_valid  out  1      an event is presented on evt_id
//   evt_id     out  ID_W   channel index of the presented event
//   level_out  out  N_CH   debounced level of each channel
//   ovf        out  N_CH   sticky flag: a rising edge was lost on this channel
//
// BEHAVIOUR
// - Reset (rst_n=0 at a posedge):
//   - level_out, ovf, pending, debounce counters, evt_valid, evt_id and rr_ptr all go to 0.
//   - The synchronizer flops are not reset.
//   - Reset is legal mid-operation: a held or queued event is dropped, and nothing is emitted during reset.
//   - After reset, an input that is still high looks like a new rising edge and produces one event after the debounce time.
// - Synchronizer: sync[i] follows async_in[i] with 2 posedges of latency.
// - Debounce, per channel:
//   - While sync[i] == level_out[i], the counter is held at 0.
//   - While they differ, the counter increments every cycle.
//   - On a differing cycle where cnt == DEB_CYCLES-1, level_out[i] flips and the counter clears.
//   - Any glitch shorter than DEB_CYCLES synchronized cycles leaves level_out unchanged.
// - Edge detect: a 0->1 flip of level_out[i] sets pending[i] on that same edge. 1->0 flips make no event.
// - Overflow: if a rising flip occurs while pending[i]=1 and channel i is not granted that cycle, ovf[i] is set.
//   - If ovf[i] is set and cleared on the same edge, set wins.
//   - ovf_clr[i] clears ovf[i] on the next edge.
// - Scheduler: the output register may load when (!evt_valid || evt_ready).
//   - Grant: the first pending channel searched from rr_ptr upward, wrapping at N_CH-1 -> 0.
//   - On grant: evt_valid=1, evt_id=g, pending[g] is cleared, rr_ptr = (g+1) mod N_CH.
//   - Wrap must be correct when N_CH is not a power of 2.
//   - If nothing is pending and evt_ready=1, evt_valid drops to 0.
//   - If a new rising flip hits the granted channel on the grant edge, pending[g] stays 1 (set wins) and ovf is not set.
// - Handshake: evt_valid and evt_id stay stable until a transfer (evt_valid && evt_ready).
//   - Back-to-back transfers run at 1 per cycle. evt_valid never drops without a transfer, except on reset.
// - Latency: take posedge t as the first edge that samples async_in[i]=1 with the input then held.
//   - level_out[i] rises at edge t+1+DEB_CYCLES.
//   - evt_valid rises at edge t+2+DEB_CYCLES, provided the output is free and there is no contention.
//
// TESTING
// 1. DEB_CYCLES=16; raise async_in[2] and hold it
//    -> level_out[2]=1 after edge t+17; evt_valid=1 with evt_id=2 after edge t+18; with evt_ready=1, one transfer, then evt_valid=0.
// 2. Pulse async_in[1] high for 10 cycles
//    -> level_out[1] stays 0, no event, counter returns to 0.
// 3. Raise channels 0,1,3 on the same cycle; evt_ready=1; rr_ptr=0
//    -> ids 0,1,3 on consecutive cycles, then rr_ptr=0 (wraps after 3).
//    -> Repeat with rr_ptr=2: order 3,0,1.
// 4. Hold evt_ready=0 with ch0 presented; toggle ch1 twice, respecting debounce
//    -> evt_id holds at 0; pending[1]=1; ovf[1]=1 on the second rise.
//    -> Assert ovf_clr[1] on the same cycle as a new rise: ovf[1] stays 1.
// 5. Assert rst_n=0 for 1 cycle while evt_valid=1 and ch2 is pending with its input held high
//    -> all outputs 0 after the edge; a ch2 event reappears DEB_CYCLES+2 edges after reset is released.
// 6. N_CH=3, all channels pending continuously; randomize evt_ready
//    -> each id appears fairly (0,1,2 in order); id never reaches 3; evt_id stable while stalled.

Source files
------------

// File: rtl/sync_event_arbiter.sv
// Async input conditioner: per-channel 2FF sync, debounce and rising-edge capture,
// merged into one valid/ready event stream by a round-robin scheduler.

module sync_event_arbiter_ch #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = $clog2(DEB_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1, r_s2, r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_flip;

  assign w_diff  = r_s2 ^ r_level;
  assign w_flip  = w_diff && (r_cnt == CNT_LAST);
  assign o_rise  = w_flip && !r_level;
  assign o_level = r_level;

  // Synchronizer flops are deliberately left out of reset.
  always_ff @(posedge clk) begin
    r_s1 <= i_async;
    r_s2 <= r_s1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

module sync_event_arbiter #(
  parameter int N_CH       = 4,
  parameter int ID_W       = $clog2(N_CH),
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = $clog2(DEB_CYCLES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] async_in,
  input  logic            evt_ready,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] ovf
);
  localparam int IW1 = ID_W + 1;

  logic [N_CH-1:0] w_rise, w_gnt_oh;
  logic [N_CH-1:0] r_pending, r_ovf;
  logic [ID_W-1:0] r_rr, r_id, w_gnt_id, w_rr_nxt;
  logic [IW1-1:0]  w_idx;
  logic            r_valid, w_load, w_gnt, w_take;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_event_arbiter_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (async_in[i]),
      .o_level (level_out[i]),
      .o_rise  (w_rise[i])
    );
  end

  // Scan offsets high-to-low so the smallest offset from r_rr wins; wrap by
  // subtraction keeps non-power-of-2 channel counts correct.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr} + IW1'(k);
      if (w_idx >= IW1'(N_CH)) w_idx = w_idx - IW1'(N_CH);
      if (r_pending[w_idx[ID_W-1:0]]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_load   = !r_valid || evt_ready;
  assign w_take   = w_load && w_gnt;
  assign w_rr_nxt = (w_gnt_id == ID_W'(N_CH - 1)) ? '0 : w_gnt_id + 1'b1;

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < N_CH; i++)
      w_gnt_oh[i] = w_take && (w_gnt_id == ID_W'(i));
  end

  // A rise on the granted channel re-arms pending without counting as lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_ovf     <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_rr      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_gnt_oh) | w_rise;
      r_ovf     <= (r_ovf & ~ovf_clr) | (w_rise & r_pending & ~w_gnt_oh);
      if (w_load) begin
        r_valid <= w_gnt;
        if (w_gnt) begin
          r_id <= w_gnt_id;
          r_rr <= w_rr_nxt;
        end
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: directed scenarios plus a randomized run against
// a cycle-level reference model built from the channel/scheduler rules.

module tb_sync_event_arbiter;
  localparam int DEB  = 16;
  localparam int DEB3 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] async_in, ovf_clr, level_out, ovf;
  logic       evt_ready, evt_valid;
  logic [1:0] evt_id;

  logic [2:0] async3, level3, ovf3;
  logic [2:0] clr3 = '0;
  logic       ready3, valid3;
  logic [1:0] id3;

  int n_cmp = 0;
  int n_bad = 0;

  sync_event_arbiter #(.N_CH(4), .DEB_CYCLES(DEB)) u_dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .evt_ready(evt_ready),
    .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_id(evt_id),
    .level_out(level_out), .ovf(ovf));

  sync_event_arbiter #(.N_CH(3), .DEB_CYCLES(DEB3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .async_in(async3), .evt_ready(ready3),
    .ovf_clr(clr3), .evt_valid(valid3), .evt_id(id3),
    .level_out(level3), .ovf(ovf3));

  always #5 clk = ~clk;

  // Reference model for the 4-channel instance.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pend = '0, m_ovf = '0;
  int         m_run [4];
  int         m_rr = 0, m_id = 0;
  logic       m_vld = 1'b0;

  task automatic model_step();
    logic [3:0] rise, nlvl;
    int g;
    logic load;
    rise = '0; nlvl = m_lvl; g = -1;
    if (!rst_n) begin
      m_lvl = '0; m_pend = '0; m_ovf = '0; m_rr = 0; m_vld = 1'b0; m_id = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      // level flips on the DEB-th consecutive cycle the synced input disagrees
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
        else if (m_run[i] + 1 == DEB) begin
          nlvl[i] = ~m_lvl[i]; m_run[i] = 0; rise[i] = nlvl[i];
        end else m_run[i]++;
      end
      load = !m_vld || evt_ready;
      if (load)
        for (int k = 0; k < 4 && g < 0; k++)
          if (m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && m_pend[i] && i != g) m_ovf[i] = 1'b1;
        else if (ovf_clr[i]) m_ovf[i] = 1'b0;
      end
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | rise;
      if (load) begin
        m_vld = (g >= 0);
        if (g >= 0) begin m_id = g; m_rr = (g + 1) % 4; end
      end
      m_lvl = nlvl;
    end
    m_s2 = m_s1;
    m_s1 = async_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; async_in = '0; ovf_clr = '0; evt_ready = 1'b0;
    async3 = '0; ready3 = 1'b0;
    repeat (3) tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_cmp++; if (evt_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
    n_cmp++; if (level_out !== 4'h0) begin n_bad++; $display("FAIL reset_level: got %b expected 0000", level_out); end
    n_cmp++; if (ovf !== 4'h0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    n_cmp++; if (valid3 !== 1'b0) begin n_bad++; $display("FAIL reset_valid3: got %b expected 0", valid3); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    evt_ready = 1'b0;
    async_in[2] = 1'b1;
    repeat (17) tick();
    n_cmp++; if (level_out[2] !== 1'b0) begin n_bad++; $display("FAIL lat_level_early: got %b expected 0", level_out[2]); end
    tick();
    n_cmp++; if (level_out[2] !== 1'b1) begin n_bad++; $display("FAIL lat_level: got %b expected 1", level_out[2]); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid_early: got %b expected 0", evt_valid); end
    tick();
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid: got %b expected 1", evt_valid); end
    n_cmp++; if (evt_id !== 2'd2) begin n_bad++; $display("FAIL lat_id: got %0d expected 2", evt_id); end
    evt_ready = 1'b1;
    tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drop: got %b expected 0", evt_valid); end
    async_in[2] = 1'b0;
    repeat (25) tick();
    n_cmp++; if (level_out !== 4'h0 || evt_valid !== 1'b0) begin n_bad++; $display("FAIL lat_fall: level %b valid %b expected 0000/0", level_out, evt_valid); end
  endtask

  task automatic test_glitch();
    bit seen = 0;
    async_in[1] = 1'b1;
    repeat (10) begin tick(); if (evt_valid) seen = 1; end
    async_in[1] = 1'b0;
    repeat (30) begin tick(); if (evt_valid || level_out[1]) seen = 1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL glitch_event: got event/level 1 expected none"); end
    n_cmp++; if (u_dut.g_ch[1].u_ch.r_cnt !== '0) begin n_bad++; $display("FAIL glitch_cnt: got %0d expected 0", u_dut.g_ch[1].u_ch.r_cnt); end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_a[3] = '{0, 1, 3};
    int exp_b[3] = '{3, 0, 1};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    evt_ready = 1'b1;
    async_in = 4'b1011;
    got = {};
    repeat (40) begin tick(); if (evt_valid) got.push_back(int'(evt_id)); end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL rr0_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] != exp_a[i]) begin n_bad++; $display("FAIL rr0_order[%0d]: got %0d expected %0d", i, got[i], exp_a[i]); end
    end
    async_in = '0; repeat (25) tick();
    async_in = 4'b0010;  // one ch1 grant moves the pointer to 2
    got = {};
    repeat (25) begin tick(); if (evt_valid) got.push_back(int'(evt_id)); end
    n_cmp++; if (got.size() != 1 || got[0] != 1) begin n_bad++; $display("FAIL rr_setup: got %0d events expected one id 1", got.size()); end
    async_in = '0; repeat (25) tick();
    async_in = 4'b1011;
    got = {};
    repeat (40) begin tick(); if (evt_valid) got.push_back(int'(evt_id)); end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL rr2_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] != exp_b[i]) begin n_bad++; $display("FAIL rr2_order[%0d]: got %0d expected %0d", i, got[i], exp_b[i]); end
    end
    async_in = '0; repeat (25) tick();
  endtask

  task automatic test_overflow();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    evt_ready = 1'b0;
    async_in[0] = 1'b1; repeat (20) tick();
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin n_bad++; $display("FAIL ovf_hold0: valid %b id %0d expected 1/0", evt_valid, evt_id); end
    async_in[1] = 1'b1; repeat (20) tick();
    n_cmp++; if (u_dut.r_pending[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_pend1: got %b expected 1", u_dut.r_pending[1]); end
    n_cmp++; if (ovf[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_first_rise: got %b expected 0", ovf[1]); end
    async_in[1] = 1'b0; repeat (20) tick();
    async_in[1] = 1'b1; repeat (20) tick();
    n_cmp++; if (ovf[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_second_rise: got %b expected 1", ovf[1]); end
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin n_bad++; $display("FAIL ovf_stall: valid %b id %0d expected 1/0", evt_valid, evt_id); end
    ovf_clr[1] = 1'b1; tick(); ovf_clr = '0;
    n_cmp++; if (ovf[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", ovf[1]); end
    async_in[1] = 1'b0; repeat (20) tick();
    async_in[1] = 1'b1; repeat (17) tick();
    n_cmp++; if (ovf[1] !== 1'b0 || level_out[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_pre_rise: ovf %b level %b expected 0/0", ovf[1], level_out[1]); end
    ovf_clr[1] = 1'b1; tick(); ovf_clr = '0;  // clear lands on the rising edge
    n_cmp++; if (ovf[1] !== 1'b1 || level_out[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: ovf %b level %b expected 1/1", ovf[1], level_out[1]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    async_in = 4'b0100; repeat (20) tick();
    n_cmp++; if (evt_valid !== 1'b1 || u_dut.r_pending[2] !== 1'b1) begin n_bad++; $display("FAIL rmid_setup: valid %b pend2 %b expected 1/1", evt_valid, u_dut.r_pending[2]); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_cmp++; if ({evt_valid, evt_id, level_out, ovf} !== 11'd0) begin n_bad++; $display("FAIL rmid_clear: valid %b id %0d level %b ovf %b expected all 0", evt_valid, evt_id, level_out, ovf); end
    evt_ready = 1'b1;
    while (!evt_valid && n < 40) begin tick(); n++; end
    // sync is already high, so 17 edges after release = DEB+2 counting the reset edge
    n_cmp++; if (n != DEB + 1) begin n_bad++; $display("FAIL rmid_latency: got %0d edges expected %0d", n, DEB + 1); end
    n_cmp++; if (evt_id !== 2'd2) begin n_bad++; $display("FAIL rmid_id: got %0d expected 2", evt_id); end
    async_in = '0; repeat (25) tick();
  endtask

  task automatic test_random();
    int hold [4];
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin async_in[i] = ~async_in[i]; hold[i] = $urandom_range(1, 40); end
        ovf_clr[i] = ($urandom_range(0, 15) == 0);
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
      n_cmp++; if (level_out !== m_lvl) begin n_bad++; $display("FAIL rnd_level c%0d: got %b expected %b", c, level_out, m_lvl); end
      n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d: got %b expected %b", c, ovf, m_ovf); end
      n_cmp++; if (evt_valid !== m_vld) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, evt_valid, m_vld); end
      if (m_vld) begin
        n_cmp++; if (evt_id !== 2'(m_id)) begin n_bad++; $display("FAIL rnd_id c%0d: got %0d expected %0d", c, evt_id, m_id); end
      end
    end
    rst_n = 1'b1; ovf_clr = '0;
  endtask

  task automatic test_three_channel();
    int n;
    bit stall;
    logic [1:0] prev_id;
    for (int r = 0; r < 4; r++) begin
      async3 = 3'b111; ready3 = 1'b0; n = 0; stall = 0; prev_id = '0;
      for (int c = 0; c < 80 && n < 3; c++) begin
        tick();
        if (stall) begin
          n_cmp++; if (valid3 !== 1'b1 || id3 !== prev_id) begin n_bad++; $display("FAIL n3_stable r%0d: valid %b id %0d expected 1/%0d", r, valid3, id3, prev_id); end
        end
        ready3 = $urandom_range(0, 1);
        if (valid3) begin
          n_cmp++; if (id3 > 2'd2) begin n_bad++; $display("FAIL n3_range r%0d: got %0d expected <3", r, id3); end
          if (ready3) begin
            n_cmp++; if (id3 !== 2'(n)) begin n_bad++; $display("FAIL n3_order r%0d: got %0d expected %0d", r, id3, n); end
            n++;
          end
        end
        stall = valid3 && !ready3;
        prev_id = id3;
      end
      n_cmp++; if (n != 3) begin n_bad++; $display("FAIL n3_timeout r%0d: got %0d transfers expected 3", r, n); end
      async3 = '0;
      repeat (12) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; async_in = '0; ovf_clr = '0; evt_ready = 1'b0;
    async3 = '0; ready3 = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_round_robin();
    test_overflow();
    test_reset_mid();
    test_random();
    test_three_channel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
